// File: rtl/face_capture_unit.sv
// Face capture datapath for the cube-scan sequencer: samples the nine sticker
// centers of each face, classifies them into color codes and stores 54 codes.
module face_capture_unit #(
    parameter logic [10:0] X0    = 11'd220,
    parameter logic [10:0] Y0    = 11'd140,
    parameter logic [10:0] PITCH = 11'd100,
    parameter logic [9:0]  HI_TH = 10'd600,
    parameter logic [9:0]  LO_TH = 10'd300
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ds,
    input  logic        gc,
    input  logic        cs,
    input  logic        cc,
    input  logic        algstart,
    input  logic [10:0] iX,
    input  logic [10:0] iY,
    input  logic [9:0]  iR,
    input  logic [9:0]  iG,
    input  logic [9:0]  iB,
    input  logic        iDVAL,
    output logic        busy,
    output logic [2:0]  face_idx,
    output logic        check_valid,
    output logic        check_ok,
    output logic        all_done,
    input  logic [5:0]  rd_addr,
    output logic [2:0]  rd_data
);

    localparam logic [10:0] X1 = X0 + PITCH;
    localparam logic [10:0] X2 = X0 + PITCH + PITCH;
    localparam logic [10:0] Y1 = Y0 + PITCH;
    localparam logic [10:0] Y2 = Y0 + PITCH + PITCH;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_SAMPLE   = 3'd2,
        ST_CLASSIFY = 3'd3,
        ST_CHECK    = 3'd4
    } state_t;

    function automatic logic [2:0] classify(input logic [9:0] r, input logic [9:0] g,
                                            input logic [9:0] b);
        logic [2:0] code;
        if ((r > HI_TH) && (g > HI_TH) && (b > HI_TH)) begin
            code = 3'd0;
        end else if ((r > HI_TH) && (g > HI_TH) && (b < LO_TH)) begin
            code = 3'd1;
        end else if ((r > HI_TH) && (g < LO_TH) && (b < LO_TH)) begin
            code = 3'd2;
        end else if ((r > HI_TH) && (g >= LO_TH) && (g <= HI_TH) && (b < LO_TH)) begin
            code = 3'd3;
        end else if ((g > HI_TH) && (r < LO_TH)) begin
            code = 3'd4;
        end else if ((b > HI_TH) && (r < LO_TH)) begin
            code = 3'd5;
        end else begin
            code = 3'd7;
        end
        return code;
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic        r_pend_gc, r_pend_cs, r_pend_cc;
    logic        w_pend_gc_next, w_pend_cs_next, w_pend_cc_next;
    logic        r_busy, w_busy_next;
    logic [8:0]  r_sv;
    logic [29:0] r_samp [0:8];
    logic [2:0]  r_store [0:53];
    logic [2:0]  r_centers [0:5];
    logic [3:0]  r_k;
    logic        r_cls_run;
    logic        r_bad;
    logic [2:0]  r_face_idx;
    logic        r_check_valid, r_check_ok, r_all_done;
    logic [2:0]  r_rd_data;

    logic        w_en, w_ds, w_gc_acc, w_cs_acc, w_cc_acc;
    logic        w_frame_start;
    logic        w_col_hit, w_row_hit;
    logic [1:0]  w_col, w_row;
    logic [3:0]  w_samp_idx;
    logic        w_samp_hit;
    logic        w_samp_en, w_cls_start, w_cls_write, w_check_fire;
    logic [3:0]  w_k_idx;
    logic [29:0] w_pix;
    logic [2:0]  w_code;
    logic        w_wr_en;
    logic [5:0]  w_wr_addr;
    logic [2:0]  w_cur_center;
    logic        w_dup;
    logic        w_ok;
    logic [2:0]  w_face_next;

    assign w_en          = (r_face_idx != 3'd6);
    assign w_ds          = ds & w_en;
    assign w_gc_acc      = gc & w_en & ((r_state != ST_SAMPLE) | w_ds);
    assign w_cs_acc      = cs & w_en;
    assign w_cc_acc      = cc & w_en;
    assign w_frame_start = iDVAL & (iX == 11'd0) & (iY == 11'd0);

    // Decode the pixel position into a sticker row/column.
    always_comb begin
        w_col_hit = 1'b1;
        w_row_hit = 1'b1;
        w_col     = 2'd0;
        w_row     = 2'd0;
        if (iX == X0) begin
            w_col = 2'd0;
        end else if (iX == X1) begin
            w_col = 2'd1;
        end else if (iX == X2) begin
            w_col = 2'd2;
        end else begin
            w_col_hit = 1'b0;
        end
        if (iY == Y0) begin
            w_row = 2'd0;
        end else if (iY == Y1) begin
            w_row = 2'd1;
        end else if (iY == Y2) begin
            w_row = 2'd2;
        end else begin
            w_row_hit = 1'b0;
        end
    end

    assign w_samp_idx = ({2'b00, w_row} * 4'd3) + {2'b00, w_col};
    assign w_samp_hit = w_samp_en & iDVAL & w_col_hit & w_row_hit & ~w_ds;

    // Sticker currently being classified; missing samples become unknown.
    assign w_k_idx   = (r_k < 4'd9) ? r_k : 4'd0;
    assign w_pix     = r_samp[w_k_idx];
    assign w_code    = r_sv[w_k_idx] ? classify(w_pix[29:20], w_pix[19:10], w_pix[9:0]) : 3'd7;
    assign w_wr_en   = w_cls_write & ~Reset;
    assign w_wr_addr = ({3'b000, r_face_idx} * 6'd9) + {2'b00, r_k};

    assign w_cur_center = (r_face_idx < 3'd6) ? r_centers[r_face_idx] : 3'd7;

    // Compare this face's center against the centers of earlier faces.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if ((3'(i) < r_face_idx) && (r_centers[i] == w_cur_center)) begin
                w_dup = 1'b1;
            end else begin
                w_dup = w_dup;
            end
        end
    end

    assign w_ok        = ~r_bad & ~w_dup;
    assign w_face_next = w_check_fire ? (r_face_idx + 3'd1) : r_face_idx;

    // Next-state, pending-flag and step-enable logic.
    always_comb begin
        w_state_next   = r_state;
        w_pend_gc_next = r_pend_gc;
        w_pend_cs_next = r_pend_cs;
        w_pend_cc_next = r_pend_cc;
        w_samp_en      = 1'b0;
        w_cls_start    = 1'b0;
        w_cls_write    = 1'b0;
        w_check_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_IDLE;
            end
            ST_ARM: begin
                if (r_pend_gc && w_frame_start) begin
                    w_state_next   = ST_SAMPLE;
                    w_pend_gc_next = 1'b0;
                end else begin
                    w_state_next = ST_ARM;
                end
            end
            ST_SAMPLE: begin
                w_samp_en = 1'b1;
                if ((&r_sv) || w_frame_start) begin
                    w_state_next = ST_CLASSIFY;
                end else begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_CLASSIFY: begin
                if (r_cls_run) begin
                    w_cls_write = 1'b1;
                    if (r_k == 4'd8) begin
                        w_state_next = ST_CHECK;
                    end else begin
                        w_state_next = ST_CLASSIFY;
                    end
                end else if (r_pend_cs) begin
                    w_cls_start    = 1'b1;
                    w_pend_cs_next = 1'b0;
                end else begin
                    w_state_next = ST_CLASSIFY;
                end
            end
            ST_CHECK: begin
                if (r_pend_cc) begin
                    w_check_fire   = 1'b1;
                    w_pend_cc_next = 1'b0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_state_next = ST_CHECK;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // A new detect-start discards everything queued for the old face.
        if (w_ds) begin
            w_state_next   = ST_ARM;
            w_pend_gc_next = 1'b0;
            w_pend_cs_next = 1'b0;
            w_pend_cc_next = 1'b0;
        end else begin
            w_state_next = w_state_next;
        end
        w_pend_gc_next = w_pend_gc_next | w_gc_acc;
        w_pend_cs_next = w_pend_cs_next | w_cs_acc;
        w_pend_cc_next = w_pend_cc_next | w_cc_acc;
        w_busy_next    = (w_state_next != ST_IDLE) | w_pend_gc_next | w_pend_cs_next
                         | w_pend_cc_next;
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Control, sequencing and status registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pend_gc     <= 1'b0;
            r_pend_cs     <= 1'b0;
            r_pend_cc     <= 1'b0;
            r_busy        <= 1'b0;
            r_sv          <= 9'd0;
            r_k           <= 4'd0;
            r_cls_run     <= 1'b0;
            r_bad         <= 1'b0;
            r_face_idx    <= 3'd0;
            r_check_valid <= 1'b0;
            r_check_ok    <= 1'b0;
            r_all_done    <= 1'b0;
        end else begin
            r_pend_gc <= w_pend_gc_next;
            r_pend_cs <= w_pend_cs_next;
            r_pend_cc <= w_pend_cc_next;
            r_busy    <= w_busy_next;
            if (w_ds) begin
                r_sv <= 9'd0;
            end else if (w_samp_hit) begin
                r_sv[w_samp_idx] <= 1'b1;
            end
            if (w_cls_start) begin
                r_k   <= 4'd0;
                r_bad <= 1'b0;
            end else if (w_cls_write) begin
                r_k   <= r_k + 4'd1;
                r_bad <= r_bad | (w_code == 3'd7);
            end
            r_cls_run     <= (w_state_next == ST_CLASSIFY) & (r_cls_run | w_cls_start);
            r_check_valid <= w_check_fire;
            if (w_check_fire) begin
                r_check_ok <= w_ok;
            end
            r_face_idx <= w_face_next;
            r_all_done <= (w_face_next == 3'd6);
        end
    end

    // Pixel samples, cube store and per-face centers hold data only.
    always_ff @(posedge Clk) begin
        if (!Reset && w_samp_hit) begin
            r_samp[w_samp_idx] <= {iR, iG, iB};
        end
        if (w_wr_en) begin
            r_store[w_wr_addr] <= w_code;
            if (r_k == 4'd4) begin
                r_centers[r_face_idx] <= w_code;
            end
        end
    end

    // Solver read port, gated by the solver phase.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd_data <= 3'd0;
        end else if (!algstart) begin
            r_rd_data <= 3'd0;
        end else if (rd_addr > 6'd53) begin
            r_rd_data <= 3'd7;
        end else begin
            r_rd_data <= r_store[rd_addr];
        end
    end

    assign busy        = r_busy;
    assign face_idx    = r_face_idx;
    assign check_valid = r_check_valid;
    assign check_ok    = r_check_ok;
    assign all_done    = r_all_done;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_face_capture_unit.sv
// Self-checking bench for face_capture_unit: randomized sticker colors drawn
// from each color's region, compared against an intended-color store model.
module tb_face_capture_unit;

    logic        Clk = 1'b0;
    logic        Reset, ds, gc, cs, cc, algstart, iDVAL;
    logic [10:0] iX, iY;
    logic [9:0]  iR, iG, iB;
    logic        busy, check_valid, check_ok, all_done;
    logic [2:0]  face_idx, rd_data;
    logic [5:0]  rd_addr;

    int checks = 0;
    int errors = 0;
    int m_store [54];
    int m_centers [$];
    int m_face;

    face_capture_unit dut (
        .Clk(Clk), .Reset(Reset), .ds(ds), .gc(gc), .cs(cs), .cc(cc),
        .algstart(algstart), .iX(iX), .iY(iY), .iR(iR), .iG(iG), .iB(iB),
        .iDVAL(iDVAL), .busy(busy), .face_idx(face_idx), .check_valid(check_valid),
        .check_ok(check_ok), .all_done(all_done), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic pix(input int x, input int y, input int r, input int g, input int b,
                       input bit dv);
        iX = 11'(x); iY = 11'(y); iR = 10'(r); iG = 10'(g); iB = 10'(b); iDVAL = dv;
        tick();
        iDVAL = 1'b0;
    endtask

    task automatic strobes();
        ds = 1'b1; tick(); ds = 1'b0;
        gc = 1'b1; tick(); gc = 1'b0;
        cs = 1'b1; tick(); cs = 1'b0;
        cc = 1'b1; tick(); cc = 1'b0;
    endtask

    // Pick a pixel value inside the region that defines the intended color.
    task automatic gen_rgb(input int code, input bit canon, output int r, output int g,
                           output int b);
        case (code)
            0: if (canon) begin r = 900; g = 900; b = 900; end
               else begin r = $urandom_range(601, 1023); g = $urandom_range(601, 1023);
                          b = $urandom_range(601, 1023); end
            1: if (canon) begin r = 900; g = 900; b = 100; end
               else begin r = $urandom_range(601, 1023); g = $urandom_range(601, 1023);
                          b = $urandom_range(0, 299); end
            2: if (canon) begin r = 900; g = 100; b = 100; end
               else begin r = $urandom_range(601, 1023); g = $urandom_range(0, 299);
                          b = $urandom_range(0, 299); end
            3: if (canon) begin r = 900; g = 450; b = 100; end
               else begin r = $urandom_range(601, 1023); g = $urandom_range(300, 600);
                          b = $urandom_range(0, 299); end
            4: if (canon) begin r = 100; g = 900; b = 100; end
               else begin r = $urandom_range(0, 299); g = $urandom_range(601, 1023);
                          b = $urandom_range(0, 1023); end
            5: if (canon) begin r = 100; g = 100; b = 900; end
               else begin r = $urandom_range(0, 299); g = $urandom_range(0, 600);
                          b = $urandom_range(601, 1023); end
            default: begin r = $urandom_range(300, 600); g = $urandom_range(300, 600);
                           b = $urandom_range(300, 600); end
        endcase
    endtask

    task automatic model_reset();
        m_face = 0;
        m_centers.delete();
    endtask

    // Expected outcome of a face: intended codes, 7 where a sticker was never seen.
    task automatic model_face(input int codes [9], input bit skip8, output bit exp_ok);
        int v;
        exp_ok = 1'b1;
        for (int k = 0; k < 9; k++) begin
            v = (skip8 && k == 8) ? 7 : codes[k];
            m_store[m_face * 9 + k] = v;
            if (v == 7) exp_ok = 1'b0;
        end
        foreach (m_centers[i]) if (m_centers[i] == m_store[m_face * 9 + 4]) exp_ok = 1'b0;
        m_centers.push_back(m_store[m_face * 9 + 4]);
        m_face++;
    endtask

    task automatic read_store(input int a, output logic [2:0] v);
        rd_addr = 6'(a);
        algstart = 1'b1;
        tick();
        v = rd_data;
    endtask

    task automatic run_face(input int codes [9], input bit skip8, input bit canon,
                            output bit seen, output bit ok_obs, output logic [2:0] fidx_obs);
        int rr [9], gg [9], bb [9], perm [9];
        int j, t;
        for (int k = 0; k < 9; k++) begin
            gen_rgb(codes[k], canon, rr[k], gg[k], bb[k]);
            perm[k] = k;
        end
        for (int k = 8; k > 0; k--) begin
            j = $urandom_range(0, k); t = perm[k]; perm[k] = perm[j]; perm[j] = t;
        end
        strobes();
        pix(0, 0, 0, 0, 0, 1'b1);
        for (int n = 0; n < 9; n++) begin
            j = perm[n];
            if (!(skip8 && j == 8)) begin
                pix($urandom_range(1, 219), $urandom_range(0, 479), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1);
                pix(220 + (j % 3) * 100, 140 + (j / 3) * 100, 450, 450, 450, 1'b0);
                pix(220 + (j % 3) * 100, 140 + (j / 3) * 100, rr[j], gg[j], bb[j], 1'b1);
            end
        end
        pix(0, 0, 0, 0, 0, 1'b1);
        seen = 1'b0; ok_obs = 1'b0; fidx_obs = 3'd0;
        for (int w = 0; w < 60 && !seen; w++) begin
            if (check_valid === 1'b1) begin
                seen = 1'b1; ok_obs = check_ok; fidx_obs = face_idx;
            end else begin
                tick();
            end
        end
        tick();
    endtask

    task automatic pulse_reset();
        Reset = 1'b1; tick(); tick(); Reset = 1'b0; tick();
        model_reset();
    endtask

    task automatic test_reset();
        algstart = 1'b0; rd_addr = 6'd0;
        pulse_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (face_idx !== 3'd0) begin errors++; $display("FAIL reset_face_idx got %0d want 0", face_idx); end
        checks++; if (check_valid !== 1'b0) begin errors++; $display("FAIL reset_check_valid got %0b want 0", check_valid); end
        checks++; if (check_ok !== 1'b0) begin errors++; $display("FAIL reset_check_ok got %0b want 0", check_ok); end
        checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL reset_all_done got %0b want 0", all_done); end
        checks++; if (rd_data !== 3'd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
    endtask

    task automatic test_first_face();
        int codes [9];
        bit seen, ok_obs, exp_ok;
        logic [2:0] fidx, v;
        for (int k = 0; k < 9; k++) codes[k] = 0;
        run_face(codes, 1'b0, 1'b1, seen, ok_obs, fidx);
        model_face(codes, 1'b0, exp_ok);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL first_check_valid got %0b want 1", seen); end
        checks++; if (ok_obs !== exp_ok) begin errors++; $display("FAIL first_check_ok got %0b want %0b", ok_obs, exp_ok); end
        checks++; if (fidx !== 3'(m_face)) begin errors++; $display("FAIL first_face_idx got %0d want %0d", fidx, m_face); end
        for (int a = 0; a < 9; a++) begin
            read_store(a, v);
            checks++; if (v !== 3'(m_store[a])) begin errors++; $display("FAIL first_store[%0d] got %0d want %0d", a, v, m_store[a]); end
        end
        algstart = 1'b0;
    endtask

    task automatic test_six_faces();
        int codes [9];
        bit seen, ok_obs, exp_ok;
        logic [2:0] fidx, v;
        for (int f = 1; f < 6; f++) begin
            for (int k = 0; k < 9; k++) codes[k] = $urandom_range(0, 5);
            codes[4] = f;
            run_face(codes, 1'b0, 1'b0, seen, ok_obs, fidx);
            model_face(codes, 1'b0, exp_ok);
            checks++; if (seen !== 1'b1 || ok_obs !== exp_ok) begin errors++; $display("FAIL six_face%0d_check got valid=%0b ok=%0b want valid=1 ok=%0b", f, seen, ok_obs, exp_ok); end
            checks++; if (fidx !== 3'(m_face)) begin errors++; $display("FAIL six_face%0d_idx got %0d want %0d", f, fidx, m_face); end
        end
        checks++; if (all_done !== 1'b1) begin errors++; $display("FAIL six_all_done got %0b want 1", all_done); end
        for (int a = 0; a < 54; a++) begin
            read_store(a, v);
            checks++; if (v !== 3'(m_store[a])) begin errors++; $display("FAIL six_store[%0d] got %0d want %0d", a, v, m_store[a]); end
        end
        read_store(22, v);
        checks++; if (v !== 3'd2) begin errors++; $display("FAIL six_rd22 got %0d want 2", v); end
        algstart = 1'b0;
        ds = 1'b1; tick(); ds = 1'b0;
        checks++; if (busy !== 1'b0 || face_idx !== 3'd6) begin errors++; $display("FAIL six_ignore_ds got busy=%0b idx=%0d want busy=0 idx=6", busy, face_idx); end
    endtask

    task automatic test_read_port();
        algstart = 1'b0; rd_addr = 6'd5; tick();
        checks++; if (rd_data !== 3'd0) begin errors++; $display("FAIL rd_gated5 got %0d want 0", rd_data); end
        rd_addr = 6'd22; tick();
        checks++; if (rd_data !== 3'd0) begin errors++; $display("FAIL rd_gated22 got %0d want 0", rd_data); end
        algstart = 1'b1; rd_addr = 6'd60; tick();
        checks++; if (rd_data !== 3'd7) begin errors++; $display("FAIL rd_oob60 got %0d want 7", rd_data); end
        algstart = 1'b0;
    endtask

    task automatic test_dup_center();
        int codes [9];
        bit seen, ok_obs, exp_ok;
        logic [2:0] fidx;
        pulse_reset();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 9; k++) codes[k] = (f == 0) ? 0 : $urandom_range(0, 5);
            if (f > 0) codes[4] = 4;
            run_face(codes, 1'b0, (f == 0), seen, ok_obs, fidx);
            model_face(codes, 1'b0, exp_ok);
            checks++; if (seen !== 1'b1 || ok_obs !== exp_ok) begin errors++; $display("FAIL dup_face%0d_check got valid=%0b ok=%0b want valid=1 ok=%0b", f, seen, ok_obs, exp_ok); end
            checks++; if (fidx !== 3'(m_face)) begin errors++; $display("FAIL dup_face%0d_idx got %0d want %0d", f, fidx, m_face); end
        end
    endtask

    task automatic test_missing_sticker();
        int codes [9];
        bit seen, ok_obs, exp_ok;
        logic [2:0] fidx, v;
        for (int k = 0; k < 9; k++) codes[k] = $urandom_range(0, 5);
        codes[4] = 1;
        run_face(codes, 1'b1, 1'b0, seen, ok_obs, fidx);
        model_face(codes, 1'b1, exp_ok);
        checks++; if (seen !== 1'b1 || ok_obs !== exp_ok) begin errors++; $display("FAIL miss_check got valid=%0b ok=%0b want valid=1 ok=%0b", seen, ok_obs, exp_ok); end
        checks++; if (fidx !== 3'(m_face)) begin errors++; $display("FAIL miss_face_idx got %0d want %0d", fidx, m_face); end
        for (int a = 27; a < 36; a++) begin
            read_store(a, v);
            checks++; if (v !== 3'(m_store[a])) begin errors++; $display("FAIL miss_store[%0d] got %0d want %0d", a, v, m_store[a]); end
        end
        algstart = 1'b0;
    endtask

    task automatic test_reset_mid_classify();
        int codes [9];
        bit seen, ok_obs, exp_ok;
        logic [2:0] fidx, v;
        pulse_reset();
        strobes();
        pix(0, 0, 0, 0, 0, 1'b1);
        for (int k = 0; k < 9; k++) pix(220 + (k % 3) * 100, 140 + (k / 3) * 100, 900, 100, 100, 1'b1);
        // Last center was taken at the previous edge; four writes land before the reset edge.
        repeat (6) tick();
        Reset = 1'b1; tick();
        checks++; if (busy !== 1'b0 || face_idx !== 3'd0) begin errors++; $display("FAIL midrst_state got busy=%0b idx=%0d want busy=0 idx=0", busy, face_idx); end
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) m_store[k] = 2;
        repeat (12) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy=%0b want 0", busy); end
        for (int a = 0; a < 9; a++) begin
            read_store(a, v);
            checks++; if (v !== 3'(m_store[a])) begin errors++; $display("FAIL midrst_store[%0d] got %0d want %0d", a, v, m_store[a]); end
        end
        algstart = 1'b0;
        model_reset();
        for (int k = 0; k < 9; k++) codes[k] = $urandom_range(0, 5);
        codes[4] = 5;
        run_face(codes, 1'b0, 1'b0, seen, ok_obs, fidx);
        model_face(codes, 1'b0, exp_ok);
        checks++; if (seen !== 1'b1 || ok_obs !== exp_ok) begin errors++; $display("FAIL restart_check got valid=%0b ok=%0b want valid=1 ok=%0b", seen, ok_obs, exp_ok); end
        checks++; if (fidx !== 3'(m_face)) begin errors++; $display("FAIL restart_face_idx got %0d want %0d", fidx, m_face); end
        for (int a = 0; a < 9; a++) begin
            read_store(a, v);
            checks++; if (v !== 3'(m_store[a])) begin errors++; $display("FAIL restart_store[%0d] got %0d want %0d", a, v, m_store[a]); end
        end
        algstart = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; ds = 1'b0; gc = 1'b0; cs = 1'b0; cc = 1'b0; algstart = 1'b0;
        iX = 11'd0; iY = 11'd0; iR = 10'd0; iG = 10'd0; iB = 10'd0; iDVAL = 1'b0;
        rd_addr = 6'd0;
        test_reset();
        test_first_face();
        test_six_faces();
        test_read_port();
        test_dup_center();
        test_missing_sticker();
        test_reset_mid_classify();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/face_capture_unit.md
Name: face_capture_unit

Overview:
- Responder datapath for the cube-scan control sequencer.
- Consumes the per-face strobe sequence `ds` (detect start), `gc` (get centers), `cs` (color store) and `cc` (color check), plus `algstart`.
- Per face: samples the 9 sticker-center pixels from the CCD pixel stream, classifies each into a color code, writes the codes into a 54-entry cube store, then runs a validity check.
- After six faces, exposes the store to the solver through a read port.

Parameters:
- X0, 11'd220, x pixel coordinate of sticker column 0 center
- Y0, 11'd140, y pixel coordinate of sticker row 0 center
- PITCH, 11'd100, center-to-center sticker spacing in pixels
- HI_TH, 10'd600, channel "high" threshold
- LO_TH, 10'd300, channel "low" threshold

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- ds  in  1  detect-start strobe, one cycle
- gc  in  1  get-centers strobe, one cycle
- cs  in  1  color-store strobe, one cycle
- cc  in  1  color-check strobe, one cycle
- algstart  in  1  solver phase active, level
- iX  in  11  current pixel x coordinate
- iY  in  11  current pixel y coordinate
- iR  in  10  pixel red
- iG  in  10  pixel green
- iB  in  10  pixel blue
- iDVAL  in  1  pixel qualifier
- busy  out  1  operation in progress or pending
- face_idx  out  3  faces completed, 0..6
- check_valid  out  1  one-cycle pulse, check result ready
- check_ok  out  1  result of last check, held
- all_done  out  1  face_idx==6
- rd_addr  in  6  store read address 0..53 (face*9 + row*3 + col)
- rd_data  out  3  color code, registered, 1-cycle latency

Behaviour:
- Clocking and reset:
  - Single clock `Clk`. `Reset` is synchronous and active-high.
  - Reset clears: busy=0, face_idx=0, check_valid=0, check_ok=0, all_done=0, rd_data=0, all pending flags, FSM to IDLE.
  - Store contents are not cleared. Reset mid-operation aborts with no further store writes.
- Color codes: 0 white, 1 yellow, 2 red, 3 orange, 4 green, 5 blue, 7 unknown.
- Request handling:
  - Strobes arrive on consecutive cycles, so each of `gc`, `cs`, `cc` sets a pending flag.
  - Pending operations execute strictly in order gc → cs → cc; each starts only after the prior completes.
  - `ds` clears all pending flags and the 9 sample-valid bits, then moves the FSM to ARM.
  - Strobes are ignored while face_idx==6.
  - busy = (state != IDLE) or any pending flag set.
- FSM states: IDLE, ARM, SAMPLE, CLASSIFY, CHECK.
- ARM:
  - Waits for pending gc.
  - Then waits for a frame start (iDVAL & iX==0 & iY==0) and enters SAMPLE.
- SAMPLE:
  - On iDVAL with iX==X0+c*PITCH and iY==Y0+r*PITCH (r,c in 0..2), latch {iR,iG,iB} into sample[r*3+c] and set its valid bit.
  - Exits when all 9 valid bits are set.
  - Also exits on the next frame start; unsampled entries are later classified as 7.
- CLASSIFY:
  - Waits for pending cs, then processes one sticker per cycle for 9 cycles.
  - Writes store[face_idx*9+k]. Latency from cs start to last write is 9 cycles.
  - Classification rules, first match wins:
    - R,G,B all > HI_TH → white
    - R>HI_TH & G>HI_TH & B<LO_TH → yellow
    - R>HI_TH & G<LO_TH & B<LO_TH → red
    - R>HI_TH & G in [LO_TH,HI_TH] & B<LO_TH → orange
    - G>HI_TH & R<LO_TH → green
    - B>HI_TH & R<LO_TH → blue
    - otherwise 7
    - Comparisons are unsigned.
- CHECK:
  - Waits for pending cc, then takes 1 cycle.
  - check_ok=1 iff no sticker on this face is 7 and this face's center code (k=4) differs from the centers of faces 0..face_idx-1.
  - Pulses check_valid for 1 cycle.
  - Increments face_idx regardless of the result (the sequencer advances on the operator's Face button).
  - Returns to IDLE.
- all_done = (face_idx==6), registered.
- Read port:
  - rd_data = store[rd_addr] one cycle later, only while algstart=1; otherwise rd_data=0.
  - rd_addr > 53 returns 7.
- Simultaneous events:
  - `ds` in the same cycle as a CLASSIFY write: the write completes and the FSM moves to ARM. Prior face writes stay intact.
  - A `gc` strobe arriving while already in SAMPLE is absorbed and not re-queued.

Test Plan:
1. Reset, then ds,gc,cs,cc on consecutive cycles; two frames with all 9 centers at R=G=B=900 → store[0..8]=0, check_valid pulse, check_ok=1, face_idx=1.
2. Six faces colored white/yellow/red/orange/green/blue (e.g. red = 900,100,100; orange = 900,450,100) → all_done=1; with algstart=1, rd_addr=22 returns 2 one cycle later.
3. Face 2 center equal to face 1 center (both green 100,900,100) → check_ok=0 and face_idx still increments.
4. Frame containing only 8 of the 9 center coordinates (missing r=2,c=2) then next frame start → store[face*9+8]=7 and check_ok=0.
5. Reset asserted mid-CLASSIFY after 4 writes → busy=0, face_idx=0, FSM IDLE, no further writes; a new ds restarts the flow cleanly.
6. algstart=0 with rd_addr=5 → rd_data=0; algstart=1 with rd_addr=60 → rd_data=7.
